cache_mem_arbiter: RTL

Arbitrates between the instruction cache miss port and the data cache miss/uncached port for the single memory port of the AXI interface. It sits directly downstream of the i-cache and d-cache and directly upstream of the AXI interface. It replaces the combinational instruction/data select mux with a registered grant state machine that latches each request, holds it stable until `mem_ready`, and cancels it cleanly on an exception flush.

---
 rtl/cache_mem_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// Registered arbiter sharing the single AXI memory port between the i-cache and d-cache miss ports.
// Optional macro ARB_ROUND_ROBIN_EN: alternate on simultaneous strobes (default: d-cache always wins).
module cache_mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_strobe,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [31:0]       i_rdata,
    input  logic              d_strobe,
    input  logic              d_rw,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [1:0]        d_size,
    input  logic [3:0]        d_sel,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    input  logic              flush,
    output logic              mem_access,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_a,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_sel,
    output logic [31:0]       mem_st_data,
    input  logic              mem_ready,
    input  logic [31:0]       mem_data,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, GRANT_I = 2'd1, GRANT_D = 2'd2} state_t;

    state_t            state_reg, state_next;
    logic              last_grant_reg, last_grant_next;   // 0 = I, 1 = D
    logic [ADDR_W-1:0] req_a_reg, req_a_next;
    logic [1:0]        req_size_reg, req_size_next;
    logic [3:0]        req_sel_reg, req_sel_next;
    logic [31:0]       req_wdata_reg, req_wdata_next;
    logic              req_write_reg, req_write_next;
    logic              i_wins_conflict;

`ifdef ARB_ROUND_ROBIN_EN
    // The requester that did not win last time takes a tie.
    assign i_wins_conflict = last_grant_reg;
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant_reg;
    assign i_wins_conflict   = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b0;
            req_a_reg      <= '0;
            req_size_reg   <= '0;
            req_sel_reg    <= '0;
            req_wdata_reg  <= '0;
            req_write_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            req_a_reg      <= req_a_next;
            req_size_reg   <= req_size_next;
            req_sel_reg    <= req_sel_next;
            req_wdata_reg  <= req_wdata_next;
            req_write_reg  <= req_write_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        req_a_next      = req_a_reg;
        req_size_next   = req_size_reg;
        req_sel_next    = req_sel_reg;
        req_wdata_next  = req_wdata_reg;
        req_write_next  = req_write_reg;
        case (state_reg)
            IDLE: begin
                if (!flush && i_strobe && (!d_strobe || i_wins_conflict)) begin
                    state_next     = GRANT_I;
                    req_a_next     = i_addr;
                    req_size_next  = 2'd2;
                    req_sel_next   = 4'b1111;
                    req_wdata_next = 32'd0;
                    req_write_next = 1'b0;
                end else if (!flush && d_strobe) begin
                    state_next     = GRANT_D;
                    req_a_next     = d_addr;
                    req_size_next  = d_size;
                    req_sel_next   = d_sel;
                    req_wdata_next = d_wdata;
                    req_write_next = d_rw;
                end
            end
            GRANT_I, GRANT_D: begin
                // Completion beats a simultaneous flush; a lone flush abandons the request silently.
                if (mem_ready) begin
                    state_next      = IDLE;
                    last_grant_next = (state_reg == GRANT_D);
                end else if (flush) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_reg != IDLE);
        mem_access  = busy;
        mem_write   = busy & req_write_reg;
        mem_a       = busy ? req_a_reg : '0;
        mem_size    = busy ? req_size_reg : 2'd0;
        mem_sel     = busy ? req_sel_reg : 4'd0;
        mem_st_data = busy ? req_wdata_reg : 32'd0;
        i_ready     = (state_reg == GRANT_I) & mem_ready;
        d_ready     = (state_reg == GRANT_D) & mem_ready;
        i_rdata     = i_ready ? mem_data : 32'd0;
        d_rdata     = d_ready ? mem_data : 32'd0;
    end

endmodule
